fence_queue_fwft: RTL and testbench
===================================

Name: fence_queue_fwft

Overview:
Next-generation raw-hits fence queue. It is a parametrised first-word-fall-through (FWFT) FIFO built on the existing dual-port ramblock. It adds:
- a registered head-of-queue output with a valid flag;
- programmable almost-full and almost-empty thresholds;
- a high-water-mark occupancy monitor;
- a clearable sticky overflow/underflow status.

It sits between the raw-hits buffer allocator (push side) and the readout sequencer (pop side).

Parameters:
- ADRB, 11, RAM address bits.
- MXADR, 2048, total capacity in words; must equal 2**ADRB.
- WIDTH, 43, data width (ADRB+32: fence address plus event data).

Ports:
- clock  in  1  IO clock.
- reset  in  1  synchronous reset, active-high.
- push  in  1  write wr_data.
- wr_data  in  WIDTH  push data.
- pop  in  1  consume head word; meaningful only while rd_valid.
- rd_data  out  WIDTH  head-of-queue word, valid while rd_valid.
- rd_valid  out  1  rd_data holds a valid head word.
- afull_thr  in  ADRB+1  almost-full threshold.
- aempty_thr  in  ADRB+1  almost-empty threshold.
- full  out  1  nwords==MXADR.
- empty  out  1  nwords==0.
- afull  out  1  nwords>=afull_thr (registered).
- aempty  out  1  nwords<=aempty_thr (registered).
- nwords  out  ADRB+1  total words held, including the head register.
- nwords_max  out  ADRB+1  high-water mark since last clear.
- stat_clr  in  1  clears ovf, udf and nwords_max.
- ovf  out  1  sticky: push while full.
- udf  out  1  sticky: pop while !rd_valid.
- sump  out  1  OR of unused/dangling signals.

Behaviour:
- Reset (synchronous, active-high) sets:
  - rd_adr=0, wr_adr=0, nwords=0, nwords_max=0;
  - rd_valid=0, ovf=0, udf=0, afull=0;
  - aempty=1 (when aempty_thr>=0), empty=1, full=0.
  - rd_data is don't-care while rd_valid=0.
- Reset mid-operation discards all contents. No partial pop completes.
- Enables:
  - push_en = push && !full.
  - pop_en = pop && rd_valid.
- Occupancy counters:
  - nwords: +1 on push_en only, -1 on pop_en only, unchanged on both or neither.
  - nram = nwords minus the staged head word; tracks RAM-resident words.
  - Both counters stay within 0..MXADR; no wrap.
- Addresses: wr_adr and rd_adr are ADRB-bit counters with natural modulo-MXADR wrap.
  - wr_adr increments on push_en.
  - rd_adr increments on each RAM prefetch.
- Prefetch:
  - Issued when nram>0 and (the head stage is empty, or pop_en this cycle).
  - RAM read has 1-cycle latency.
  - The head stage is loaded on the following edge, and rd_valid is set.
- Latency:
  - Push at edge k into an empty queue: rd_valid=1 and rd_data=wr_data after edge k+2.
  - Back-to-back pops sustain 1 word/clock while nram>0. There is no bubble between consecutive words.
- pop_en with nothing left to prefetch: rd_valid falls after that edge.
- Read-during-write: the same RAM address is never read in the cycle it is written, because nram gating prevents it. No bypass path is needed.
- Simultaneous push and pop:
  - when full: push is accepted because the pop frees a slot in the same cycle, so push_en uses full && !pop_en. ovf is not set.
  - when nwords==1: nwords stays 1, and the new word becomes head after the 2-cycle latency. rd_valid drops for exactly those 2 cycles.
- Thresholds:
  - afull and aempty are registered from next-state nwords, so they align with nwords.
  - Threshold ports are sampled every cycle; they are static by system convention.
  - afull_thr=0 gives afull always 1. aempty_thr>=MXADR gives aempty always 1.
- nwords_max <= max(nwords_max, next nwords) each cycle.
- stat_clr:
  - has priority over new ovf/udf events in the same cycle;
  - sets nwords_max to the current next-state nwords.
- ovf/udf: set on the first offending cycle; held until stat_clr or reset.

Decomposition:
- Shared include/package:
  - default ADRB/MXADR/WIDTH for the raw-hits buffer;
  - the derived WIDTH = ADRB+32 constant;
  - a nwords-width localparam.
- Single sub-module: existing ramblock (RAM_WIDTH=WIDTH, RAM_ADRB=ADRB); its dang output feeds sump.
- All control logic stays in fence_queue_fwft.

Test Plan:
1. After reset, push 0x1 at edge 0 → rd_valid=1, rd_data=0x1 after edge 2. Before that: empty=0 from edge 1, nwords=1.
2. Push 2048 words (data = index), ADRB=11 → full=1, nwords=2048, nwords_max=2048. An extra push sets ovf=1 and wr_adr is unchanged. Then pop continuously → rd_data 0..2047 in order, one per clock, no bubbles. Finally empty=1 and rd_valid=0.
3. When full, assert push and pop together → word accepted, ovf=0, nwords stays 2048. After a full drain, data order is preserved across the wr_adr wrap.
4. afull_thr=4, aempty_thr=1; push 5 words, then pop all → afull rises at the edge where nwords=4 and falls at nwords=3. aempty=1 at nwords≤1.
5. Pop when rd_valid=0 → udf=1 and nwords stays 0. Then stat_clr → udf=0, ovf=0, nwords_max=current nwords. A stat_clr coincident with a new pop-while-empty leaves udf=0.
6. Reset asserted with 10 words queued and pop active → after that edge: nwords=0, rd_valid=0, empty=1, nwords_max=0. A subsequent push of 0xABC is read back as the first word.

Source files
------------

// File: rtl/fence_queue_fwft_pkg.sv
// Shared sizing for the raw-hits fence queue: default RAM geometry and derived widths.
package fence_queue_fwft_pkg;

    localparam int ADRB_DEF  = 11;
    localparam int MXADR_DEF = 2 ** ADRB_DEF;
    localparam int WIDTH_DEF = ADRB_DEF + 32;
    localparam int NWB_DEF   = ADRB_DEF + 1;

    // Occupancy counters need one extra bit so a completely full RAM is representable.
    function automatic int nwb(input int adrb);
        return adrb + 1;
    endfunction

endpackage

// File: rtl/fence_queue_fwft_ramblock.sv
// Simple dual-port RAM with registered read; rd_data holds its value while rd_en is low.
module ramblock
    import fence_queue_fwft_pkg::*;
#(
    parameter int RAM_WIDTH = WIDTH_DEF,
    parameter int RAM_ADRB  = ADRB_DEF
) (
    input  logic                 clock,
    input  logic                 wr_en,
    input  logic [RAM_ADRB-1:0]  wr_adr,
    input  logic [RAM_WIDTH-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [RAM_ADRB-1:0]  rd_adr,
    output logic [RAM_WIDTH-1:0] rd_data,
    output logic                 dang
);

    logic [RAM_WIDTH-1:0] mem [2**RAM_ADRB];

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_adr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_adr];
    end

    assign dang = 1'b0;

endmodule

// File: rtl/fence_queue_fwft.sv
// First-word-fall-through fence queue: RAM, one-word prefetch stage and registered head word,
// plus thresholds, high-water mark and sticky overflow/underflow status.
module fence_queue_fwft
    import fence_queue_fwft_pkg::*;
#(
    parameter int ADRB  = ADRB_DEF,
    parameter int MXADR = MXADR_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic [ADRB:0]    afull_thr,
    input  logic [ADRB:0]    aempty_thr,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic             aempty,
    output logic [ADRB:0]    nwords,
    output logic [ADRB:0]    nwords_max,
    input  logic             stat_clr,
    output logic             ovf,
    output logic             udf,
    output logic             sump
);

    localparam int NWB = nwb(ADRB);

    logic [ADRB-1:0]  wr_adr;
    logic [ADRB-1:0]  rd_adr;
    logic [NWB-1:0]   nram;
    logic [NWB-1:0]   nwords_n;
    logic [WIDTH-1:0] ram_q;
    logic             ob_valid;
    logic             push_en;
    logic             pop_en;
    logic             head_free;
    logic             prefetch;
    logic             ram_dang;

    assign full      = (nwords == NWB'(MXADR));
    assign empty     = (nwords == '0);
    assign pop_en    = pop && rd_valid;
    assign push_en   = push && (!full || pop_en);
    assign head_free = !rd_valid || pop_en;
    // The RAM output register acts as a second stage; refill it whenever it drains this cycle.
    assign prefetch  = (nram != '0) && (!ob_valid || head_free);
    assign nwords_n  = nwords + NWB'(push_en) - NWB'(pop_en);

    ramblock #(
        .RAM_WIDTH (WIDTH),
        .RAM_ADRB  (ADRB)
    ) u_ram (
        .clock   (clock),
        .wr_en   (push_en),
        .wr_adr  (wr_adr),
        .wr_data (wr_data),
        .rd_en   (prefetch),
        .rd_adr  (rd_adr),
        .rd_data (ram_q),
        .dang    (ram_dang)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_adr     <= '0;
            rd_adr     <= '0;
            nram       <= '0;
            nwords     <= '0;
            nwords_max <= '0;
            ob_valid   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            afull      <= 1'b0;
            aempty     <= 1'b1;
            ovf        <= 1'b0;
            udf        <= 1'b0;
        end else begin
            if (push_en)  wr_adr <= wr_adr + ADRB'(1);
            if (prefetch) rd_adr <= rd_adr + ADRB'(1);
            nram     <= nram + NWB'(push_en) - NWB'(prefetch);
            nwords   <= nwords_n;
            ob_valid <= (ob_valid && !head_free) || prefetch;
            if (head_free) begin
                rd_valid <= ob_valid;
                if (ob_valid) rd_data <= ram_q;
            end
            afull  <= (nwords_n >= afull_thr);
            aempty <= (nwords_n <= aempty_thr);
            if (stat_clr) begin
                ovf        <= 1'b0;
                udf        <= 1'b0;
                nwords_max <= nwords_n;
            end else begin
                if (push && full && !pop_en) ovf <= 1'b1;
                if (pop && !rd_valid)        udf <= 1'b1;
                if (nwords_n > nwords_max)   nwords_max <= nwords_n;
            end
        end
    end

    assign sump = ram_dang;

endmodule

// File: tb/tb_fence_queue_fwft.sv
// Bench for fence_queue_fwft: hand-derived vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_fence_queue_fwft;
    import fence_queue_fwft_pkg::*;

    localparam int ADRB = ADRB_DEF;
    localparam int MX   = MXADR_DEF;
    localparam int W    = WIDTH_DEF;
    localparam int NWB  = ADRB + 1;

    logic           clock = 1'b0;
    logic           reset, push, pop, stat_clr;
    logic [W-1:0]   wr_data, rd_data;
    logic [NWB-1:0] afull_thr, aempty_thr, nwords, nwords_max;
    logic           rd_valid, full, empty, afull, aempty, ovf, udf, sump;

    always #5 clock = ~clock;

    fence_queue_fwft dut (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .wr_data    (wr_data),
        .pop        (pop),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .afull_thr  (afull_thr),
        .aempty_thr (aempty_thr),
        .full       (full),
        .empty      (empty),
        .afull      (afull),
        .aempty     (aempty),
        .nwords     (nwords),
        .nwords_max (nwords_max),
        .stat_clr   (stat_clr),
        .ovf        (ovf),
        .udf        (udf),
        .sump       (sump)
    );

    // Reference model: each word is visible at the head no earlier than two edges after its
    // push, and no earlier than the edge its predecessor left.
    typedef struct {
        logic [W-1:0] data;
        int           ready;
    } ent_t;

    ent_t mq[$];
    int   m_max;
    bit   m_ovf, m_udf, m_afull, m_aempty, m_valid;
    int   edge_n = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    typedef struct {
        bit           push, pop, clr;
        logic [W-1:0] d;
        int           nw;
        bit           rv;
        logic [W-1:0] rd;
        bit           udf;
        int           mx;
    } vec_t;

    vec_t tv[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", name, edge_n, act, exp);
        end
    endtask

    task automatic model_edge();
        bit   pe, we;
        int   cnt;
        ent_t e;
        edge_n++;
        if (reset) begin
            mq.delete();
            m_max = 0; m_ovf = 0; m_udf = 0; m_afull = 0; m_aempty = 1; m_valid = 0;
            return;
        end
        pe = pop && m_valid;
        we = push && ((mq.size() < MX) || pe);
        if (stat_clr) begin
            m_ovf = 0; m_udf = 0;
        end else begin
            if (push && !we)    m_ovf = 1;
            if (pop && !m_valid) m_udf = 1;
        end
        if (pe) begin
            void'(mq.pop_front());
            if (mq.size() > 0 && mq[0].ready < edge_n) begin
                e = mq[0]; e.ready = edge_n; mq[0] = e;
            end
        end
        if (we) begin
            e.data = wr_data; e.ready = edge_n + 2;
            mq.push_back(e);
        end
        cnt = mq.size();
        if (stat_clr) m_max = cnt;
        else if (cnt > m_max) m_max = cnt;
        m_afull  = (cnt >= int'(afull_thr));
        m_aempty = (cnt <= int'(aempty_thr));
        m_valid  = (cnt > 0) && (mq[0].ready <= edge_n);
    endtask

    task automatic compare_all();
        check("nwords",     64'(nwords),     64'(mq.size()));
        check("rd_valid",   64'(rd_valid),   64'(m_valid));
        if (m_valid) check("rd_data", 64'(rd_data), 64'(mq[0].data));
        check("full",       64'(full),       64'(mq.size() == MX));
        check("empty",      64'(empty),      64'(mq.size() == 0));
        check("afull",      64'(afull),      64'(m_afull));
        check("aempty",     64'(aempty),     64'(m_aempty));
        check("nwords_max", 64'(nwords_max), 64'(m_max));
        check("ovf",        64'(ovf),        64'(m_ovf));
        check("udf",        64'(udf),        64'(m_udf));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        push = 0; pop = 0; stat_clr = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        reset = 1; push = 0; pop = 0; stat_clr = 0;
        step();
        step();
        reset = 0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog edge=%0d got=timeout want=finish", edge_n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1; push = 0; pop = 0; stat_clr = 0; wr_data = '0;
        afull_thr = NWB'(4); aempty_thr = NWB'(1);

        //             push pop clr  d      nw rv rd  udf mx
        tv[0]  = '{1, 0, 0, W'(1), 1, 0, W'(0), 0, 1};
        tv[1]  = '{0, 0, 0, W'(0), 1, 0, W'(0), 0, 1};
        tv[2]  = '{0, 0, 0, W'(0), 1, 1, W'(1), 0, 1};
        tv[3]  = '{0, 1, 0, W'(0), 0, 0, W'(0), 0, 1};
        tv[4]  = '{0, 1, 0, W'(0), 0, 0, W'(0), 1, 1};
        tv[5]  = '{0, 0, 1, W'(0), 0, 0, W'(0), 0, 0};
        tv[6]  = '{0, 1, 1, W'(0), 0, 0, W'(0), 0, 0};
        tv[7]  = '{1, 0, 0, W'(2), 1, 0, W'(0), 0, 1};
        tv[8]  = '{1, 0, 0, W'(3), 2, 0, W'(0), 0, 2};
        tv[9]  = '{0, 0, 0, W'(0), 2, 1, W'(2), 0, 2};
        tv[10] = '{0, 1, 0, W'(0), 1, 1, W'(3), 0, 2};
        tv[11] = '{1, 1, 0, W'(4), 1, 0, W'(0), 0, 2};
        tv[12] = '{0, 0, 0, W'(0), 1, 0, W'(0), 0, 2};
        tv[13] = '{0, 0, 0, W'(0), 1, 1, W'(4), 0, 2};
        tv[14] = '{0, 1, 0, W'(0), 0, 0, W'(0), 0, 2};

        apply_reset();
        check("rst_nwords", 64'(nwords), 64'(0));
        check("rst_valid",  64'(rd_valid), 64'(0));
        check("rst_empty",  64'(empty), 64'(1));
        check("rst_full",   64'(full), 64'(0));
        check("rst_aempty", 64'(aempty), 64'(1));
        check("rst_afull",  64'(afull), 64'(0));
        check("rst_max",    64'(nwords_max), 64'(0));
        check("rst_status", 64'({ovf, udf}), 64'(0));

        for (int i = 0; i < 15; i++) begin
            push = tv[i].push; pop = tv[i].pop; stat_clr = tv[i].clr; wr_data = tv[i].d;
            step();
            check("tv_nwords", 64'(nwords), 64'(tv[i].nw));
            check("tv_valid",  64'(rd_valid), 64'(tv[i].rv));
            if (tv[i].rv) check("tv_data", 64'(rd_data), 64'(tv[i].rd));
            check("tv_empty",  64'(empty), 64'(tv[i].nw == 0));
            check("tv_udf",    64'(udf), 64'(tv[i].udf));
            check("tv_max",    64'(nwords_max), 64'(tv[i].mx));
        end
        idle(1);

        // Fill to capacity, overflow attempt, then push+pop while full and a full drain.
        apply_reset();
        for (int i = 0; i < MX; i++) begin
            push = 1; wr_data = W'(i);
            step();
        end
        push = 0;
        check("fill_full",   64'(full), 64'(1));
        check("fill_nwords", 64'(nwords), 64'(MX));
        check("fill_max",    64'(nwords_max), 64'(MX));
        push = 1; wr_data = W'(12345);
        step();
        push = 0;
        check("ovf_set",     64'(ovf), 64'(1));
        check("ovf_nwords",  64'(nwords), 64'(MX));
        stat_clr = 1;
        step();
        stat_clr = 0;
        check("ovf_clr",     64'(ovf), 64'(0));
        push = 1; pop = 1; wr_data = W'(MX);
        step();
        push = 0; pop = 0;
        check("pp_full_ovf",    64'(ovf), 64'(0));
        check("pp_full_nwords", 64'(nwords), 64'(MX));
        for (int j = 0; j < MX; j++) begin
            check("drain_valid", 64'(rd_valid), 64'(1));
            check("drain_data",  64'(rd_data), 64'(j + 1));
            pop = 1;
            step();
        end
        pop = 0;
        check("drain_empty", 64'(empty), 64'(1));
        check("drain_valid_end", 64'(rd_valid), 64'(0));

        // Threshold edges with afull_thr=4, aempty_thr=1.
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            push = 1; wr_data = W'(100 + i);
            step();
            check("thr_afull_up",  64'(afull), 64'(i >= 4));
            check("thr_aempty_up", 64'(aempty), 64'(i <= 1));
        end
        idle(2);
        for (int i = 4; i >= 0; i--) begin
            pop = 1;
            step();
            check("thr_afull_dn",  64'(afull), 64'(i >= 4));
            check("thr_aempty_dn", 64'(aempty), 64'(i <= 1));
        end
        pop = 0;

        // Reset with words queued and a pop in flight.
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            push = 1; wr_data = W'(200 + i);
            step();
        end
        push = 0;
        idle(3);
        pop = 1; reset = 1;
        step();
        pop = 0; reset = 0;
        check("mid_rst_nwords", 64'(nwords), 64'(0));
        check("mid_rst_valid",  64'(rd_valid), 64'(0));
        check("mid_rst_empty",  64'(empty), 64'(1));
        check("mid_rst_max",    64'(nwords_max), 64'(0));
        push = 1; wr_data = W'('hABC);
        step();
        push = 0;
        idle(2);
        check("mid_rst_first_valid", 64'(rd_valid), 64'(1));
        check("mid_rst_first_data",  64'(rd_data), 64'('hABC));

        // Randomized traffic: filling phase with ordinary thresholds, then a draining phase
        // with both thresholds at their always-asserted extremes.
        afull_thr  = NWB'($urandom_range(1, 300));
        aempty_thr = NWB'($urandom_range(0, 300));
        for (int c = 0; c < 1500; c++) begin
            push     = ($urandom_range(0, 99) < 70);
            pop      = ($urandom_range(0, 99) < 40);
            stat_clr = ($urandom_range(0, 99) < 2);
            wr_data  = W'({$urandom(), $urandom()});
            step();
        end
        afull_thr  = NWB'(0);
        aempty_thr = NWB'(MX);
        for (int c = 0; c < 1500; c++) begin
            push     = ($urandom_range(0, 99) < 30);
            pop      = ($urandom_range(0, 99) < 80);
            stat_clr = ($urandom_range(0, 99) < 2);
            wr_data  = W'({$urandom(), $urandom()});
            step();
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
